operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DATA_W, default 16: operand word width in bits.
REQ-002 Parameter N_WORDS, default 16: words per operand matrix (4x4, row-major).
REQ-003 Parameter ADDR_W, default 5: operand buffer address width.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles spent waiting for done.
REQ-005 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 load_start  input  1  request to begin one load-and-run sequence.
REQ-008 s_valid  input  1  upstream word valid.
REQ-009 s_data  input  DATA_W  upstream operand word.
REQ-010 s_ready  output  1  loader accepts a word this cycle.
REQ-011 wr_en_A  output  1  write strobe, matrix A buffer.
REQ-012 wr_en_B  output  1  write strobe, matrix B buffer.
REQ-013 wr_addr  output  ADDR_W  buffer write address.
REQ-014 wr_data  output  DATA_W  buffer write data.
REQ-015 en  output  1  run enable to array controller, level.
REQ-016 done  input  1  array controller completion; may stay high after completion.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 cmp_done  output  1  one-cycle pulse on successful completion.
REQ-019 timeout_err  output  1  one-cycle pulse when the done wait expires.

Function
REQ-020 The block SHALL implement states IDLE, LOAD_A, LOAD_B, RUN.
REQ-021 IDLE -> LOAD_A when load_start=1; load_start in any other state is ignored.
REQ-022 s_ready SHALL be 1 exactly in LOAD_A and LOAD_B (combinational from state).
REQ-023 Handshake = s_valid & s_ready at a rising edge; s_valid without s_ready is ignored and no word is consumed.
REQ-024 Each handshake SHALL produce, on the following cycle only, wr_en_A (LOAD_A) or wr_en_B (LOAD_B) =1 with wr_addr = word index 0..N_WORDS-1 and wr_data = accepted s_data; write latency is 1 cycle.
REQ-025 The word index SHALL reset to 0 on entry to LOAD_A and to LOAD_B.
REQ-026 The N_WORDS-th handshake in LOAD_A SHALL move to LOAD_B; in LOAD_B it SHALL move to RUN; no word is accepted in the transition cycle's successor beyond that count.
REQ-027 wr_en_A and wr_en_B SHALL never be high together.
REQ-028 en SHALL be 1 throughout RUN, 0 elsewhere; a cycle counter starts at 0 on RUN entry.
REQ-029 In RUN, a rising edge of done (done=1, previous-cycle done=0) SHALL: drop en, pulse cmp_done for 1 cycle, return to IDLE.
REQ-030 done held high from a previous run SHALL NOT complete a new run; only a fresh 0->1 edge counts.
REQ-031 If TIMEOUT cycles elapse in RUN without a done edge, the block SHALL drop en, pulse timeout_err for 1 cycle, return to IDLE.
REQ-032 A done edge on the same cycle the counter reaches TIMEOUT SHALL count as success (cmp_done, no timeout_err).
REQ-033 done edges outside RUN SHALL be ignored.
REQ-034 Upper wr_addr bits beyond the index range SHALL be 0.

Reset
REQ-035 With rst_n=0 at a rising edge, state SHALL become IDLE and s_ready, wr_en_A, wr_en_B, en, busy, cmp_done, timeout_err, wr_addr, wr_data, word index, cycle counter, done-history register SHALL all be 0.
REQ-036 Reset mid-load or mid-run SHALL abandon the sequence with no further writes and en=0 from the next cycle.

Verification
REQ-037 load_start, then 32 back-to-back words 0x0001..0x0020 -> wr_en_A at addr 0..15 with data 0x0001..0x0010, then wr_en_B at addr 0..15 with 0x0011..0x0020, each one cycle after its handshake; en rises after the 32nd.
REQ-038 s_valid toggled randomly during LOAD_A/LOAD_B -> exactly 32 writes, addresses contiguous, no duplicate or skipped data.
REQ-039 done held high entering RUN, falling then rising 20 cycles later -> cmp_done one pulse only at the fresh edge, en=0 next cycle, busy=0.
REQ-040 No done in RUN with TIMEOUT=255 -> timeout_err pulse exactly 255 cycles after RUN entry, en=0, state IDLE.
REQ-041 rst_n=0 after 7 A words -> all outputs 0 next cycle; new load_start restarts at wr_addr 0 of A.
REQ-042 load_start and s_valid asserted during LOAD_B and RUN -> no restart, no extra writes, sequence completes normally.

Source files
------------

// File: rtl/operand_loader.sv
// operand_loader
//   Streams two 4x4 operand matrices (A then B, row-major) from an upstream
//   valid/ready source into two operand buffers, then enables the array
//   controller and waits for its completion, with a bounded wait.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   load_start  begin one load-and-run sequence (honoured only in IDLE)
//   s_valid     upstream word valid
//   s_data      upstream operand word
//   s_ready     loader accepts a word this cycle (LOAD_A / LOAD_B)
//   wr_en_A     write strobe for the matrix A buffer
//   wr_en_B     write strobe for the matrix B buffer
//   wr_addr     buffer write address (word index, zero-extended)
//   wr_data     buffer write data
//   en          run enable to the array controller (level, high in RUN)
//   done        array controller completion (may stay high)
//   busy        high whenever not IDLE
//   cmp_done    one-cycle pulse on successful completion
//   timeout_err one-cycle pulse when the done wait expires
module operand_loader #(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 16,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en_A,
  output logic              wr_en_B,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              en,
  input  logic              done,
  output logic              busy,
  output logic              cmp_done,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
  // The edge that would take the counter to TIMEOUT is the last one spent
  // waiting; deciding on the pre-increment value keeps the compare registered.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;
  logic              wr_en_a_q, wr_en_a_d;
  logic              wr_en_b_q, wr_en_b_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              cmp_done_q, cmp_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic handshake;
  logic done_rise;

  assign s_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy      = (state_q != IDLE);
  assign en        = (state_q == RUN);
  assign handshake = s_valid & s_ready;
  // Only a fresh 0->1 transition counts, so a done left high by the
  // previous run cannot complete the next one.
  assign done_rise = done & ~done_q;

  assign wr_en_A     = wr_en_a_q;
  assign wr_en_B     = wr_en_b_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cmp_done    = cmp_done_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    wr_en_a_d     = 1'b0;
    wr_en_b_d     = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    cmp_done_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end

      LOAD_A: begin
        if (handshake) begin
          wr_en_a_d = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = s_data;
          if (idx_q == LAST_IDX) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      LOAD_B: begin
        if (handshake) begin
          wr_en_b_d = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = s_data;
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      RUN: begin
        // Completion wins over expiry when both land on the same edge.
        if (done_rise) begin
          state_d    = IDLE;
          cmp_done_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      wr_en_a_q     <= 1'b0;
      wr_en_b_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      cmp_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      done_q        <= done;
      wr_en_a_q     <= wr_en_a_d;
      wr_en_b_q     <= wr_en_b_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cmp_done_q    <= cmp_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed testbench for operand_loader. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_operand_loader;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          wr_en_A;
  logic          wr_en_B;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          en;
  logic          done;
  logic          busy;
  logic          cmp_done;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          is_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t cap_q[$];
  int  overlap_cnt = 0;

  operand_loader #(
    .DATA_W (16),
    .N_WORDS(16),
    .ADDR_W (5),
    .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wr_en_A    (wr_en_A),
    .wr_en_B    (wr_en_B),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .en         (en),
    .done       (done),
    .busy       (busy),
    .cmp_done   (cmp_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Record every buffer write as seen on the falling edge.
  always @(negedge clk) begin
    if (wr_en_A && wr_en_B) overlap_cnt++;
    if (wr_en_A || wr_en_B) cap_q.push_back({wr_en_B, wr_addr, wr_data});
  end

  // Pulse load_start from IDLE; returns on the falling edge with state LOAD_A.
  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Stream 32 words back to back starting at base; returns with state RUN.
  task automatic drive_words(input logic [DW-1:0] base);
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %0h want 0", s_ready); end
    n_cmp++; if (wr_en_A !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en_A: got %0h want 0", wr_en_A); end
    n_cmp++; if (wr_en_B !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en_B: got %0h want 0", wr_en_B); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    n_cmp++; if (wr_data !== 16'h0) begin n_bad++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %0h want 0", en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_cmp++; if (cmp_done !== 1'b0) begin n_bad++; $display("FAIL reset_cmp_done: got %0h want 0", cmp_done); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %0h want 0", timeout_err); end
    rst_n = 1'b1;
    @(negedge clk);
    // A done edge while IDLE must be ignored.
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_done_ignored: got cmp_done=%0h busy=%0h want 0 0", cmp_done, busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    logic          exp_a;
    start_load();
    n_cmp++; if (s_ready !== 1'b1 || busy !== 1'b1 || en !== 1'b0) begin n_bad++; $display("FAIL b2b_enter_load_a: got s_ready=%0h busy=%0h en=%0h want 1 1 0", s_ready, busy, en); end
    for (int k = 0; k < 32; k++) begin
      w       = DW'(k + 1);
      exp_a   = (k < 16);
      s_valid = 1'b1;
      s_data  = w;
      @(negedge clk);
      n_cmp++;
      if (wr_en_A !== exp_a || wr_en_B !== !exp_a || wr_addr !== AW'(k % 16) || wr_data !== w) begin
        n_bad++;
        $display("FAIL b2b_write[%0d]: got A=%0h B=%0h addr=%0h data=%0h want A=%0h B=%0h addr=%0h data=%0h",
                 k, wr_en_A, wr_en_B, wr_addr, wr_data, exp_a, !exp_a, k % 16, w);
      end
      n_cmp++; if (en !== (k == 31)) begin n_bad++; $display("FAIL b2b_en[%0d]: got %0h want %0h", k, en, (k == 31)); end
    end
    s_valid = 1'b0;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_run_s_ready: got %0h want 0", s_ready); end
    @(negedge clk);
    n_cmp++; if (wr_en_A !== 1'b0 || wr_en_B !== 1'b0) begin n_bad++; $display("FAIL b2b_no_extra_write: got A=%0h B=%0h want 0 0", wr_en_A, wr_en_B); end
    done = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b1 || en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_complete: got cmp_done=%0h en=%0h busy=%0h want 1 0 0", cmp_done, en, busy); end
    done = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b0) begin n_bad++; $display("FAIL b2b_cmp_done_width: got %0h want 0", cmp_done); end
  endtask

  task automatic test_random_valid();
    int   idx;
    int   cyc;
    logic v;
    logic rdy;
    wr_t  e;
    cap_q.delete();
    overlap_cnt = 0;
    start_load();
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 1000) begin
      v       = 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = 16'h0100 + DW'(idx);
      rdy     = s_ready;
      @(negedge clk);
      cyc++;
      if (v && rdy) idx++;
    end
    s_valid = 1'b0;
    n_cmp++; if (idx != 32) begin n_bad++; $display("FAIL rand_budget: got %0d words want 32", idx); end
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL rand_en: got %0h want 1", en); end
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_cmp++; if (cmp_done !== 1'b1) begin n_bad++; $display("FAIL rand_cmp_done: got %0h want 1", cmp_done); end
    @(negedge clk);
    n_cmp++; if (cap_q.size() != 32) begin n_bad++; $display("FAIL rand_write_count: got %0d want 32", cap_q.size()); end
    for (int i = 0; i < 32 && i < cap_q.size(); i++) begin
      e = cap_q[i];
      n_cmp++;
      if (e.is_b !== (i >= 16) || e.addr !== AW'(i % 16) || e.data !== (16'h0100 + DW'(i))) begin
        n_bad++;
        $display("FAIL rand_write[%0d]: got b=%0h addr=%0h data=%0h want b=%0h addr=%0h data=%0h",
                 i, e.is_b, e.addr, e.data, (i >= 16), i % 16, 16'h0100 + DW'(i));
      end
    end
    n_cmp++; if (overlap_cnt != 0) begin n_bad++; $display("FAIL rand_overlap: got %0d want 0", overlap_cnt); end
  endtask

  task automatic test_done_held();
    int pulses;
    done = 1'b1;
    @(negedge clk);
    start_load();
    drive_words(16'h0200);
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL held_en_entry: got %0h want 1", en); end
    pulses = 0;
    repeat (5) begin @(negedge clk); if (cmp_done === 1'b1) pulses++; end
    done = 1'b0;
    repeat (20) begin @(negedge clk); if (cmp_done === 1'b1) pulses++; end
    n_cmp++; if (pulses != 0 || en !== 1'b1) begin n_bad++; $display("FAIL held_no_early_done: got pulses=%0d en=%0h want 0 1", pulses, en); end
    done = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b1 || en !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL held_fresh_edge: got cmp_done=%0h en=%0h busy=%0h tmo=%0h want 1 0 0 0", cmp_done, en, busy, timeout_err); end
    pulses = 0;
    repeat (5) begin @(negedge clk); if (cmp_done === 1'b1) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL held_single_pulse: got %0d extra pulses want 0", pulses); end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad_cycles;
    done = 1'b0;
    start_load();
    drive_words(16'h0300);
    bad_cycles = 0;
    for (int k = 1; k < 255; k++) begin
      @(negedge clk);
      if (en !== 1'b1 || timeout_err !== 1'b0) bad_cycles++;
    end
    n_cmp++; if (bad_cycles != 0) begin n_bad++; $display("FAIL timeout_wait: got %0d bad cycles want 0", bad_cycles); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1 || en !== 1'b0 || busy !== 1'b0 || cmp_done !== 1'b0) begin n_bad++; $display("FAIL timeout_fire: got tmo=%0h en=%0h busy=%0h cmp=%0h want 1 0 0 0", timeout_err, en, busy, cmp_done); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_width: got %0h want 0", timeout_err); end
  endtask

  task automatic test_done_at_timeout();
    done = 1'b0;
    start_load();
    drive_words(16'h0380);
    repeat (254) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b1 || timeout_err !== 1'b0 || en !== 1'b0) begin n_bad++; $display("FAIL edge_at_limit: got cmp=%0h tmo=%0h en=%0h want 1 0 0", cmp_done, timeout_err, en); end
    done = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL edge_at_limit_after: got cmp=%0h tmo=%0h want 0 0", cmp_done, timeout_err); end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0400 + DW'(i);
      @(negedge clk);
    end
    n_cmp++; if (wr_en_A !== 1'b1 || wr_addr !== 5'd6) begin n_bad++; $display("FAIL midrst_pre: got A=%0h addr=%0h want 1 6", wr_en_A, wr_addr); end
    rst_n  = 1'b0;
    s_data = 16'h0407;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || wr_en_A !== 1'b0 || wr_en_B !== 1'b0 || en !== 1'b0 || busy !== 1'b0 ||
        wr_addr !== 5'd0 || wr_data !== 16'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rdy=%0h A=%0h B=%0h en=%0h busy=%0h addr=%0h data=%0h want all 0",
               s_ready, wr_en_A, wr_en_B, en, busy, wr_addr, wr_data);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_load();
    s_valid = 1'b1;
    s_data  = 16'h04AA;
    @(negedge clk);
    s_valid = 1'b0;
    n_cmp++; if (wr_en_A !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 16'h04AA) begin n_bad++; $display("FAIL midrst_restart: got A=%0h addr=%0h data=%0h want 1 0 04aa", wr_en_A, wr_addr, wr_data); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int  bad_cycles;
    wr_t e;
    cap_q.delete();
    overlap_cnt = 0;
    done = 1'b0;
    start_load();
    for (int i = 0; i < 32; i++) begin
      if (i == 16) load_start = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'h0500 + DW'(i);
      @(negedge clk);
    end
    s_data = 16'hDEAD;
    bad_cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (en !== 1'b1 || s_ready !== 1'b0) bad_cycles++;
    end
    n_cmp++; if (bad_cycles != 0) begin n_bad++; $display("FAIL ign_run_hold: got %0d bad cycles want 0", bad_cycles); end
    done       = 1'b1;
    load_start = 1'b0;
    s_valid    = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmp_done !== 1'b1 || en !== 1'b0) begin n_bad++; $display("FAIL ign_complete: got cmp=%0h en=%0h want 1 0", cmp_done, en); end
    done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle: got busy=%0h want 0", busy); end
    n_cmp++; if (cap_q.size() != 32) begin n_bad++; $display("FAIL ign_write_count: got %0d want 32", cap_q.size()); end
    for (int i = 0; i < 32 && i < cap_q.size(); i++) begin
      e = cap_q[i];
      n_cmp++;
      if (e.is_b !== (i >= 16) || e.addr !== AW'(i % 16) || e.data !== (16'h0500 + DW'(i))) begin
        n_bad++;
        $display("FAIL ign_write[%0d]: got b=%0h addr=%0h data=%0h want b=%0h addr=%0h data=%0h",
                 i, e.is_b, e.addr, e.data, (i >= 16), i % 16, 16'h0500 + DW'(i));
      end
    end
    n_cmp++; if (overlap_cnt != 0) begin n_bad++; $display("FAIL ign_overlap: got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_valid();
    test_done_held();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_load();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
